// File: rtl/job_dispatcher_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | job_dispatcher_if                                                        |
// | Descriptor stream, slot-load bus, batch control and status bundle for    |
// | the job dispatcher.                                                      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface job_dispatcher_if #(
  parameter int NUM_DECOMPRESSOR = 2
);
  // host-side descriptor stream
  logic                        desc_valid;
  logic                        desc_ready;
  logic [63:0]                 desc_src_addr;
  logic [63:0]                 desc_des_addr;
  logic [34:0]                 desc_comp_len;
  logic [31:0]                 desc_decomp_len;
  logic                        desc_last;
  // per-slot load bus
  logic                        job_valid_o;
  logic [15:0]                 job_id_o;
  logic [63:0]                 src_addr_o;
  logic [63:0]                 des_addr_o;
  logic [34:0]                 compression_length_o;
  logic [31:0]                 decompression_length_o;
  // batch control and status
  logic                        start_o;
  logic                        io_idle_i;
  logic                        io_done_i;
  logic [NUM_DECOMPRESSOR-1:0] dec_done_i;
  logic                        batch_done_o;
  logic                        busy_o;
  logic [31:0]                 jobs_done_cnt_o;
  logic                        err_o;

  // dispatcher side
  modport slave (
    input  desc_valid, desc_src_addr, desc_des_addr, desc_comp_len,
           desc_decomp_len, desc_last, io_idle_i, io_done_i, dec_done_i,
    output desc_ready, job_valid_o, job_id_o, src_addr_o, des_addr_o,
           compression_length_o, decompression_length_o, start_o,
           batch_done_o, busy_o, jobs_done_cnt_o, err_o
  );

  // host / environment side
  modport master (
    output desc_valid, desc_src_addr, desc_des_addr, desc_comp_len,
           desc_decomp_len, desc_last, io_idle_i, io_done_i, dec_done_i,
    input  desc_ready, job_valid_o, job_id_o, src_addr_o, des_addr_o,
           compression_length_o, decompression_length_o, start_o,
           batch_done_o, busy_o, jobs_done_cnt_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/job_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | job_dispatcher                                                           |
// | Packs descriptors into batches of up to NUM_DECOMPRESSOR slots, loads    |
// | each slot, starts the batch, waits for I/O and decompressors, and keeps  |
// | completed-job statistics.                                                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module job_dispatcher #(
  parameter int NUM_DECOMPRESSOR = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  job_dispatcher_if.slave  bus
);

  // slot counter is wide enough to hold NUM_DECOMPRESSOR itself
  localparam int                SLOT_W    = $clog2(NUM_DECOMPRESSOR + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DECOMPRESSOR - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic [SLOT_W-1:0]           slot_q, slot_d;
  logic [NUM_DECOMPRESSOR-1:0] batch_mask_q, batch_mask_d;
  // set for the single cycle after the closing acceptance, so START follows
  // the final load strobe rather than coinciding with it
  logic                        close_q, close_d;
  logic                        job_valid_q, job_valid_d;
  logic [15:0]                 job_id_q, job_id_d;
  logic [63:0]                 src_addr_q, src_addr_d;
  logic [63:0]                 des_addr_q, des_addr_d;
  logic [34:0]                 comp_len_q, comp_len_d;
  logic [31:0]                 decomp_len_q, decomp_len_d;
  logic [31:0]                 jobs_done_cnt_q, jobs_done_cnt_d;
  logic                        err_q, err_d;

  logic                        desc_ready;
  logic                        accept;
  logic                        desc_nonzero;
  logic [31:0]                 batch_pop;

  assign desc_ready   = (state_q == S_LOAD) && !close_q;
  assign accept       = desc_ready && bus.desc_valid;
  assign desc_nonzero = (bus.desc_comp_len != '0) && (bus.desc_decomp_len != '0);

  // number of slots loaded in the current batch
  always_comb begin
    batch_pop = '0;
    for (int i = 0; i < NUM_DECOMPRESSOR; i++) begin
      batch_pop = batch_pop + 32'(batch_mask_q[i]);
    end
  end

  // next-state, slot bookkeeping and load-bus capture
  always_comb begin
    state_d         = state_q;
    slot_d          = slot_q;
    batch_mask_d    = batch_mask_q;
    close_d         = 1'b0;
    job_valid_d     = 1'b0;
    job_id_d        = job_id_q;
    src_addr_d      = src_addr_q;
    des_addr_d      = des_addr_q;
    comp_len_d      = comp_len_q;
    decomp_len_d    = decomp_len_q;
    jobs_done_cnt_d = jobs_done_cnt_q;
    err_d           = err_q;

    case (state_q)
      S_IDLE: begin
        slot_d       = '0;
        batch_mask_d = '0;
        if (bus.io_idle_i) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (close_q) begin
          state_d = (batch_mask_q != '0) ? S_START : S_IDLE;
        end else if (accept) begin
          if (desc_nonzero) begin
            job_valid_d  = 1'b1;
            job_id_d     = 16'(slot_q);
            src_addr_d   = bus.desc_src_addr;
            des_addr_d   = bus.desc_des_addr;
            comp_len_d   = bus.desc_comp_len;
            decomp_len_d = bus.desc_decomp_len;
            slot_d       = slot_q + SLOT_W'(1);
            batch_mask_d = batch_mask_q | (NUM_DECOMPRESSOR'(1) << slot_q);
          end else begin
            err_d = 1'b1;
          end
          // a zero-length drop never fills a slot, so only real loads close on full
          if (bus.desc_last || (desc_nonzero && (slot_q == LAST_SLOT))) begin
            close_d = 1'b1;
          end
        end
      end

      S_START: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.io_done_i && (&(bus.dec_done_i | ~batch_mask_q))) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        jobs_done_cnt_d = jobs_done_cnt_q + batch_pop;
        state_d         = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      slot_q          <= '0;
      batch_mask_q    <= '0;
      close_q         <= 1'b0;
      job_valid_q     <= 1'b0;
      job_id_q        <= '0;
      src_addr_q      <= '0;
      des_addr_q      <= '0;
      comp_len_q      <= '0;
      decomp_len_q    <= '0;
      jobs_done_cnt_q <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      slot_q          <= slot_d;
      batch_mask_q    <= batch_mask_d;
      close_q         <= close_d;
      job_valid_q     <= job_valid_d;
      job_id_q        <= job_id_d;
      src_addr_q      <= src_addr_d;
      des_addr_q      <= des_addr_d;
      comp_len_q      <= comp_len_d;
      decomp_len_q    <= decomp_len_d;
      jobs_done_cnt_q <= jobs_done_cnt_d;
      err_q           <= err_d;
    end
  end

  assign bus.desc_ready             = desc_ready;
  assign bus.job_valid_o            = job_valid_q;
  assign bus.job_id_o               = job_id_q;
  assign bus.src_addr_o             = src_addr_q;
  assign bus.des_addr_o             = des_addr_q;
  assign bus.compression_length_o   = comp_len_q;
  assign bus.decompression_length_o = decomp_len_q;
  assign bus.start_o                = (state_q == S_START);
  assign bus.batch_done_o           = (state_q == S_DONE);
  assign bus.busy_o                 = (state_q != S_IDLE);
  assign bus.jobs_done_cnt_o        = jobs_done_cnt_q;
  assign bus.err_o                  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_job_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_job_dispatcher                                                        |
// | Self-checking bench for job_dispatcher with a batch-level reference      |
// | model (expected loads, error flag and completed-job count).              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_job_dispatcher;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  job_dispatcher_if #(.NUM_DECOMPRESSOR(N)) bus ();
  job_dispatcher #(.NUM_DECOMPRESSOR(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // reference model state: what the block should report
  logic [31:0] m_cnt;
  logic        m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.desc_valid      = 1'b0;
    bus.desc_last       = 1'b0;
    bus.desc_src_addr   = '0;
    bus.desc_des_addr   = '0;
    bus.desc_comp_len   = '0;
    bus.desc_decomp_len = '0;
  endtask

  // Offers ndesc descriptors (index zero_idx gets a zero length), then
  // drives the completion side and checks the batch against the model.
  task automatic run_batch(input string tag, input int ndesc, input int zero_idx,
                           input bit set_last, input bit early_done, input int dly);
    int          loaded;
    int          w;
    logic [N-1:0] mask_m;
    logic [N-1:0] lowest;
    logic [N-1:0] junk;
    logic [63:0] s;
    logic [63:0] d;
    logic [34:0] cl;
    logic [31:0] dl;
    bit          nz;
    loaded = 0;
    mask_m = '0;
    for (int i = 0; i < ndesc; i++) begin
      s  = {$urandom, $urandom};
      d  = {$urandom, $urandom};
      cl = 35'($urandom_range(1, 32'h00FF_FFFF)) << $urandom_range(0, 3);
      dl = $urandom_range(1, 32'hFFFF_FFFF);
      if (i == zero_idx) begin
        if ($urandom_range(0, 1) == 1) cl = '0;
        else dl = '0;
      end
      bus.desc_valid      = 1'b1;
      bus.desc_src_addr   = s;
      bus.desc_des_addr   = d;
      bus.desc_comp_len   = cl;
      bus.desc_decomp_len = dl;
      bus.desc_last       = set_last && (i == ndesc - 1);
      if (i == 0) begin
        w = 0;
        while (!bus.desc_ready && w < 50) begin
          @(negedge clk);
          w++;
        end
        chk({tag, "_ready_first"}, 64'(bus.desc_ready), 64'd1);
      end else begin
        chk({tag, "_ready_b2b"}, 64'(bus.desc_ready), 64'd1);
      end
      @(negedge clk);
      nz = (cl != '0) && (dl != '0);
      chk({tag, "_job_valid"}, 64'(bus.job_valid_o), 64'(nz));
      if (nz) begin
        chk({tag, "_job_id"}, 64'(bus.job_id_o), 64'(loaded));
        chk({tag, "_src"}, bus.src_addr_o, s);
        chk({tag, "_des"}, bus.des_addr_o, d);
        chk({tag, "_clen"}, 64'(bus.compression_length_o), 64'(cl));
        chk({tag, "_dlen"}, 64'(bus.decompression_length_o), 64'(dl));
        mask_m[loaded] = 1'b1;
        loaded++;
      end else begin
        m_err = 1'b1;
      end
      chk({tag, "_err"}, 64'(bus.err_o), 64'(m_err));
    end
    // now in the cycle of the final strobe; the batch must be closed
    idle_inputs();
    chk({tag, "_ready_closed"}, 64'(bus.desc_ready), 64'd0);
    if (early_done && loaded > 0) begin
      bus.io_done_i  = 1'b1;
      bus.dec_done_i = mask_m;
    end
    @(negedge clk);
    chk({tag, "_start"}, 64'(bus.start_o), 64'(loaded > 0));
    if (loaded == 0) begin
      chk({tag, "_busy_back_idle"}, 64'(bus.busy_o), 64'd0);
      @(negedge clk);
      chk({tag, "_no_start"}, 64'(bus.start_o), 64'd0);
      chk({tag, "_no_done"}, 64'(bus.batch_done_o), 64'd0);
      chk({tag, "_cnt_same"}, 64'(bus.jobs_done_cnt_o), 64'(m_cnt));
      return;
    end
    if (early_done) begin
      @(negedge clk);
      chk({tag, "_min_gap"}, 64'(bus.batch_done_o), 64'd0);
      chk({tag, "_start_once"}, 64'(bus.start_o), 64'd0);
    end else begin
      for (int k = 0; k < dly; k++) begin
        @(negedge clk);
        chk({tag, "_wait_busy"}, 64'({bus.busy_o, bus.batch_done_o, bus.start_o}), 64'b100);
      end
      // I/O done but one loaded slot still running: no completion
      lowest = mask_m & (~mask_m + 1'b1);
      junk   = N'($urandom) & ~mask_m;
      bus.io_done_i  = 1'b1;
      bus.dec_done_i = (mask_m ^ lowest) | junk;
      @(negedge clk);
      chk({tag, "_partial_dec"}, 64'(bus.batch_done_o), 64'd0);
      // all decompressors done but I/O not: no completion
      bus.io_done_i  = 1'b0;
      bus.dec_done_i = mask_m | junk;
      @(negedge clk);
      chk({tag, "_io_pending"}, 64'(bus.batch_done_o), 64'd0);
      bus.io_done_i = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_batch_done"}, 64'(bus.batch_done_o), 64'd1);
    m_cnt = m_cnt + 32'(loaded);
    bus.io_done_i  = 1'b0;
    bus.dec_done_i = '0;
    @(negedge clk);
    chk({tag, "_done_once"}, 64'(bus.batch_done_o), 64'd0);
    chk({tag, "_cnt"}, 64'(bus.jobs_done_cnt_o), 64'(m_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int zi;
    m_cnt = '0;
    m_err = 1'b0;
    rst_n = 1'b0;
    idle_inputs();
    bus.io_idle_i  = 1'b0;
    bus.io_done_i  = 1'b0;
    bus.dec_done_i = '0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_ready", 64'(bus.desc_ready), 64'd0);
    chk("rst_outs", 64'({bus.job_valid_o, bus.start_o, bus.batch_done_o, bus.busy_o, bus.err_o}), 64'd0);
    chk("rst_job_id", 64'(bus.job_id_o), 64'd0);
    chk("rst_addr", bus.src_addr_o | bus.des_addr_o, 64'd0);
    chk("rst_len", 64'(bus.compression_length_o) | 64'(bus.decompression_length_o), 64'd0);
    chk("rst_cnt", 64'(bus.jobs_done_cnt_o), 64'd0);

    // I/O not idle: descriptor offered but never taken
    rst_n = 1'b1;
    bus.desc_valid    = 1'b1;
    bus.desc_comp_len = 35'd7;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("io_busy_ready", 64'({bus.desc_ready, bus.busy_o}), 64'd0);
    end
    bus.io_idle_i = 1'b1;
    @(negedge clk);
    chk("io_idle_ready", 64'(bus.desc_ready), 64'd1);

    run_batch("pair", 2, -1, 1'b1, 1'b0, 10);
    run_batch("single", 1, -1, 1'b1, 1'b0, 2);
    run_batch("zero_only", 1, 0, 1'b1, 1'b0, 0);
    run_batch("after_zero", 3, -1, 1'b1, 1'b1, 0);
    run_batch("full_nolast", N, -1, 1'b0, 1'b1, 0);
    run_batch("full_last", N, -1, 1'b1, 1'b0, 3);
    run_batch("zero_mid", 3, 1, 1'b1, 1'b0, 1);

    // reset one cycle after the first strobe
    while (!bus.desc_ready) @(negedge clk);
    bus.desc_valid      = 1'b1;
    bus.desc_src_addr   = 64'h1234;
    bus.desc_des_addr   = 64'h5678;
    bus.desc_comp_len   = 35'd100;
    bus.desc_decomp_len = 32'd400;
    bus.desc_last       = 1'b0;
    @(negedge clk);
    chk("mid_rst_strobe", 64'(bus.job_valid_o), 64'd1);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    m_cnt = '0;
    m_err = 1'b0;
    chk("mid_rst_outs", 64'({bus.desc_ready, bus.job_valid_o, bus.start_o, bus.batch_done_o, bus.busy_o, bus.err_o}), 64'd0);
    chk("mid_rst_data", bus.src_addr_o | bus.des_addr_o | 64'(bus.job_id_o) | 64'(bus.compression_length_o) | 64'(bus.decompression_length_o), 64'd0);
    chk("mid_rst_cnt", 64'(bus.jobs_done_cnt_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_no_start", 64'(bus.start_o), 64'd0);
    run_batch("post_rst", 2, -1, 1'b1, 1'b0, 1);

    // counter wrap
    force dut.jobs_done_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.jobs_done_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("wrap_preload", 64'(bus.jobs_done_cnt_o), 64'(m_cnt));
    run_batch("wrap", 2, -1, 1'b1, 1'b0, 2);
    chk("wrap_value", 64'(bus.jobs_done_cnt_o), 64'd1);

    // randomized batches
    for (int r = 0; r < 6; r++) begin
      nd = $urandom_range(1, N);
      zi = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nd - 1) : -1;
      run_batch($sformatf("rand%0d", r), nd, zi, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/job_dispatcher.md
# job_dispatcher

Batch scheduler placed in front of the Snappy I/O controller and the decompressor array. Accepts job descriptors (source/destination address, compressed/decompressed lengths) from the host-side command stream. Packs up to NUM_DECOMPRESSOR descriptors into a batch, loads each one into a decompressor slot, and pulses start. Waits for I/O and all loaded decompressors to finish, then reports batch completion and maintains job statistics.

## Interface
- NUM_DECOMPRESSOR, 2: number of decompressor slots per batch, 1..32.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  descriptor accepted when desc_valid & desc_ready.
- desc_src_addr  in  64  compressed source address.
- desc_des_addr  in  64  decompressed destination address.
- desc_comp_len  in  35  compressed length, bytes.
- desc_decomp_len  in  32  decompressed length, bytes.
- desc_last  in  1  closes the current batch after this descriptor.
- job_valid_o  out  1  one-cycle load strobe for one slot.
- job_id_o  out  16  slot index being loaded.
- src_addr_o, des_addr_o  out  64 each  registered copies of the accepted descriptor.
- compression_length_o  out  35  registered copy.
- decompression_length_o  out  32  registered copy.
- start_o  out  1  one-cycle batch start pulse.
- io_idle_i  in  1  I/O controller idle.
- io_done_i  in  1  I/O controller all reads/writes complete (level).
- dec_done_i  in  NUM_DECOMPRESSOR  per-decompressor done (level).
- batch_done_o  out  1  one-cycle pulse per completed batch.
- busy_o  out  1  high outside IDLE.
- jobs_done_cnt_o  out  32  total jobs completed, wraps at 2^32.
- err_o  out  1  sticky: a zero-length descriptor was dropped.

## Operation
- State machine: IDLE, LOAD, START, WAIT, DONE.
- IDLE:
  - desc_ready=0.
  - Go to LOAD when io_idle_i=1.
  - Clear slot counter `slot` and mask `batch_mask`.
- LOAD:
  - desc_ready=1.
  - Each accepted descriptor with desc_comp_len!=0 and desc_decomp_len!=0 is registered.
  - On the next cycle: job_valid_o=1, job_id_o=slot (zero-extended), address/length outputs carry that descriptor.
  - Then slot increments and batch_mask[slot] is set.
  - A descriptor with either length 0 is consumed without a load strobe, and err_o is set. Its desc_last is still honoured.
  - The batch closes when the accepted descriptor is desc_last, or when slot reaches NUM_DECOMPRESSOR-1 on acceptance.
  - desc_ready drops in the cycle after the closing acceptance.
  - On close, go to START if batch_mask (including the final load) is non-zero. Otherwise return to IDLE.
- START:
  - Entered the cycle after the last job_valid_o.
  - start_o=1 for exactly one cycle.
  - Go to WAIT.
- WAIT:
  - Completion condition: io_done_i=1 and (dec_done_i | ~batch_mask) all ones.
  - Unloaded slots are ignored.
  - On completion, go to DONE.
- DONE:
  - batch_done_o=1 for one cycle.
  - jobs_done_cnt_o += popcount(batch_mask), 32-bit modulo.
  - Go to IDLE.
- Address/length outputs hold their last value between strobes.
- err_o clears only on reset.

## Timing
- Reset values: desc_ready=0, job_valid_o=0, job_id_o=0, all address/length outputs 0, start_o=0, batch_done_o=0, busy_o=0, jobs_done_cnt_o=0, err_o=0. State is IDLE.
- Latency:
  - Acceptance to job_valid_o: 1 cycle.
  - Last job_valid_o to start_o: 1 cycle.
  - Completion condition true to batch_done_o: 1 cycle.
- Back-to-back acceptance is allowed: one job_valid_o per cycle, no bubbles.
- A full batch of N descriptors takes N consecutive cycles of load strobes.
- desc_valid low in LOAD: wait indefinitely, no timeout.
- The batch stays open until desc_last or full.
- io_done_i/dec_done_i high on WAIT entry:
  - The block does not sample them in START.
  - Completion is taken at the earliest in the first WAIT cycle.
  - Minimum start_o to batch_done_o is 2 cycles.
- Simultaneous desc_last and batch-full: one close, no double action.
- Zero-length descriptor as the only item in a batch: no start_o, no batch_done_o, err_o=1, counter unchanged.
- rst_n low mid-batch: all state returns to reset values on the next edge, the partial batch is discarded, and no start_o or batch_done_o is emitted.
- busy_o is combinational from state (state!=IDLE).

## Test plan
- Two descriptors, second with desc_last, N=2, io_done_i and dec_done_i=2'b11 raised 10 cycles after start_o:
  - job_valid_o on consecutive cycles with job_id_o 0 then 1.
  - start_o exactly 1 cycle after the second strobe.
  - batch_done_o 1 cycle after the dones rise.
  - jobs_done_cnt_o=2.
- N=4, one descriptor with desc_last, io_done_i=1 and dec_done_i=4'b0001:
  - batch completes; unloaded slots ignored.
  - Counter +1.
- Descriptor with desc_comp_len=0 and desc_last:
  - consumed, err_o=1, no job_valid_o/start_o, return to IDLE.
  - Next valid batch runs normally, err_o stays 1.
- io_idle_i=0 with desc_valid=1:
  - desc_ready stays 0 until io_idle_i rises.
  - Then acceptance on the following cycle.
- rst_n asserted one cycle after the first job_valid_o:
  - all outputs at reset values; no start_o.
  - New batch afterwards restarts at job_id_o 0.
- Preload jobs_done_cnt to 0xFFFFFFFF (force), complete a 2-job batch:
  - counter wraps to 1.
